// File: rtl/adaptive_signal_ctrl.sv
// Adaptive intersection controller: queue-scaled green times, skippable left-turn and walk
// phases, all-red clearance and level-driven emergency pre-emption, stepped by a 1 s tick.
module adaptive_signal_ctrl #(
    parameter int CNT_W      = 3,
    parameter int TIME_W     = 6,
    parameter int MORE_TH    = 4,
    parameter int T_MG_BASE  = 20,
    parameter int T_MG_LONG  = 25,
    parameter int T_MG_SHORT = 15,
    parameter int T_SG_BASE  = 10,
    parameter int T_SG_LONG  = 15,
    parameter int T_SG_SHORT = 5,
    parameter int T_PG_BASE  = 10,
    parameter int T_PG_LONG  = 20,
    parameter int T_L        = 6,
    parameter int T_Y        = 3,
    parameter int T_AR       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [CNT_W-1:0]  main_num,
    input  logic [CNT_W-1:0]  left_num,
    input  logic [CNT_W-1:0]  sec_num,
    input  logic [CNT_W-1:0]  p_num,
    input  logic              m_emergency,
    input  logic              s_emergency,
    output logic [3:0]        m_LRYG,
    output logic [2:0]        s_RYG,
    output logic              ped,
    output logic [3:0]        phase,
    output logic [TIME_W-1:0] remain
);

    typedef enum logic [3:0] {
        ST_AR    = 4'd0,
        ST_M_G   = 4'd1,
        ST_M_Y   = 4'd2,
        ST_M_L   = 4'd3,
        ST_S_G   = 4'd4,
        ST_S_Y   = 4'd5,
        ST_P_G   = 4'd6,
        ST_EMG_M = 4'd7,
        ST_EMG_S = 4'd8
    } state_t;

    localparam logic [31:0] MORE_TH_U = MORE_TH;

    function automatic bit fits(input int t);
        return (t >= 0) && (t < (1 << TIME_W));
    endfunction

    if (!(fits(T_MG_BASE) && fits(T_MG_LONG) && fits(T_MG_SHORT) &&
          fits(T_SG_BASE) && fits(T_SG_LONG) && fits(T_SG_SHORT) &&
          fits(T_PG_BASE) && fits(T_PG_LONG) && fits(T_L) && fits(T_Y) && fits(T_AR))) begin : g_bad_duration
        $error("adaptive_signal_ctrl: a phase duration does not fit in TIME_W bits");
    end

    // Phase length chosen at entry; emergency phases are untimed and park at zero.
    function automatic logic [TIME_W-1:0] dur_of(input state_t st, input logic m_more,
                                                 input logic s_more, input logic p_more);
        logic [TIME_W-1:0] d;
        case (st)
            ST_AR:  d = TIME_W'(T_AR);
            ST_M_G: begin
                if (m_more)                d = TIME_W'(T_MG_LONG);
                else if (s_more || p_more) d = TIME_W'(T_MG_SHORT);
                else                       d = TIME_W'(T_MG_BASE);
            end
            ST_M_Y: d = TIME_W'(T_Y);
            ST_M_L: d = TIME_W'(T_L);
            ST_S_G: begin
                if (s_more)      d = TIME_W'(T_SG_LONG);
                else if (m_more) d = TIME_W'(T_SG_SHORT);
                else             d = TIME_W'(T_SG_BASE);
            end
            ST_S_Y: d = TIME_W'(T_Y);
            ST_P_G: d = p_more ? TIME_W'(T_PG_LONG) : TIME_W'(T_PG_BASE);
            ST_EMG_M, ST_EMG_S: d = {TIME_W{1'b0}};
            default: d = TIME_W'(T_AR);
        endcase
        if ((d == {TIME_W{1'b0}}) && (st != ST_EMG_M) && (st != ST_EMG_S)) begin
            d = TIME_W'(1);
        end
        return d;
    endfunction

    // Lamp pattern {m_LRYG, s_RYG, ped} for a state; unknown codes show all-red.
    function automatic logic [7:0] lamps_of(input state_t st);
        logic [7:0] l;
        case (st)
            ST_M_G, ST_EMG_M: l = {4'b0001, 3'b100, 1'b0};
            ST_M_Y:           l = {4'b0010, 3'b100, 1'b0};
            ST_M_L:           l = {4'b1100, 3'b100, 1'b0};
            ST_S_G, ST_EMG_S: l = {4'b0100, 3'b001, 1'b0};
            ST_S_Y:           l = {4'b0100, 3'b010, 1'b0};
            ST_P_G:           l = {4'b0100, 3'b100, 1'b1};
            default:          l = {4'b0100, 3'b100, 1'b0};
        endcase
        return l;
    endfunction

    state_t              state_r, nxt_r, state_s, nxt_s;
    logic [TIME_W-1:0]   remain_r, remain_s;
    logic                pend_m_r, pend_s_r, pend_m_s, pend_s_s;
    logic                load_s, dec_s;
    logic [7:0]          lamps_s;

    wire eff_m_s    = m_emergency;
    wire eff_s_s    = s_emergency & ~m_emergency;
    wire expire_s   = tick & (remain_r <= TIME_W'(1));
    wire m_more_s   = 32'(main_num) >= MORE_TH_U;
    wire s_more_s   = 32'(sec_num)  >= MORE_TH_U;
    wire p_more_s   = 32'(p_num)    >= MORE_TH_U;

    // Next-state, timer and pending-emergency computation.
    always_comb begin
        state_s  = state_r;
        nxt_s    = nxt_r;
        remain_s = remain_r;
        pend_m_s = pend_m_r;
        pend_s_s = pend_s_r;
        load_s   = 1'b0;
        dec_s    = 1'b0;
        case (state_r)
            ST_AR: begin
                if (eff_m_s)      pend_m_s = 1'b1;
                else if (eff_s_s) pend_s_s = 1'b1;
                else              pend_m_s = pend_m_r;
                if (expire_s) begin
                    load_s = 1'b1;
                    if (pend_m_s)      state_s = ST_EMG_M;
                    else if (pend_s_s) state_s = ST_EMG_S;
                    else               state_s = nxt_r;
                end else begin
                    dec_s = tick;
                end
            end
            ST_M_G: begin
                if (eff_m_s) begin
                    state_s = ST_M_G;
                end else if (eff_s_s) begin
                    state_s  = ST_M_Y;
                    load_s   = 1'b1;
                    pend_s_s = 1'b1;
                end else if (expire_s) begin
                    state_s = ST_M_Y;
                    load_s  = 1'b1;
                end else begin
                    dec_s = tick;
                end
            end
            ST_M_Y, ST_S_Y: begin
                if (eff_m_s)      pend_m_s = 1'b1;
                else if (eff_s_s) pend_s_s = 1'b1;
                else              pend_s_s = pend_s_r;
                if (expire_s) begin
                    state_s = ST_AR;
                    load_s  = 1'b1;
                    if (state_r == ST_M_Y) nxt_s = (left_num != {CNT_W{1'b0}}) ? ST_M_L : ST_S_G;
                    else                   nxt_s = (p_num != {CNT_W{1'b0}}) ? ST_P_G : ST_M_G;
                end else begin
                    dec_s = tick;
                end
            end
            ST_M_L, ST_P_G: begin
                if (eff_m_s || eff_s_s || expire_s) begin
                    state_s  = ST_AR;
                    load_s   = 1'b1;
                    nxt_s    = (state_r == ST_M_L) ? ST_S_G : ST_M_G;
                    pend_m_s = pend_m_r | eff_m_s;
                    pend_s_s = pend_s_r | eff_s_s;
                end else begin
                    dec_s = tick;
                end
            end
            ST_S_G: begin
                if (eff_m_s) begin
                    state_s  = ST_S_Y;
                    load_s   = 1'b1;
                    pend_m_s = 1'b1;
                end else if (eff_s_s) begin
                    state_s = ST_S_G;
                end else if (expire_s) begin
                    state_s = ST_S_Y;
                    load_s  = 1'b1;
                end else begin
                    dec_s = tick;
                end
            end
            ST_EMG_M: begin
                if (!m_emergency) begin
                    state_s = ST_M_Y;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_EMG_M;
                end
            end
            ST_EMG_S: begin
                // A main request overrides an active secondary pre-emption via the secondary yellow.
                if (m_emergency) begin
                    state_s  = ST_S_Y;
                    load_s   = 1'b1;
                    pend_m_s = 1'b1;
                end else if (!s_emergency) begin
                    state_s = ST_S_Y;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_EMG_S;
                end
            end
            default: begin
                state_s  = ST_AR;
                nxt_s    = ST_M_G;
                load_s   = 1'b1;
                pend_m_s = 1'b0;
                pend_s_s = 1'b0;
            end
        endcase
        if (load_s) begin
            remain_s = dur_of(state_s, m_more_s, s_more_s, p_more_s);
            if (state_s == ST_EMG_M)      pend_m_s = 1'b0;
            else if (state_s == ST_EMG_S) pend_s_s = 1'b0;
            else                          pend_m_s = pend_m_s;
        end else if (dec_s) begin
            remain_s = remain_r - TIME_W'(1);
        end else begin
            remain_s = remain_r;
        end
        lamps_s = lamps_of(state_s);
    end

    // State, timer and registered lamp outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r                 <= ST_AR;
            nxt_r                   <= ST_M_G;
            remain_r                <= dur_of(ST_AR, 1'b0, 1'b0, 1'b0);
            pend_m_r                <= 1'b0;
            pend_s_r                <= 1'b0;
            {m_LRYG, s_RYG, ped}    <= lamps_of(ST_AR);
        end else begin
            state_r                 <= state_s;
            nxt_r                   <= nxt_s;
            remain_r                <= remain_s;
            pend_m_r                <= pend_m_s;
            pend_s_r                <= pend_s_s;
            {m_LRYG, s_RYG, ped}    <= lamps_s;
        end
    end

    assign phase  = state_r;
    assign remain = remain_r;

endmodule

// File: tb/tb_adaptive_signal_ctrl.sv
// Scoreboard bench for adaptive_signal_ctrl: directed phase/timer checkpoints plus a random
// soak with a per-cycle conflicting-green check.
module tb_adaptive_signal_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [2:0] main_num = 3'd0, left_num = 3'd0, sec_num = 3'd0, p_num = 3'd0;
    logic       m_emergency = 1'b0, s_emergency = 1'b0;
    logic [3:0] m_LRYG;
    logic [2:0] s_RYG;
    logic       ped;
    logic [3:0] phase;
    logic [5:0] remain;

    adaptive_signal_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick),
        .main_num(main_num), .left_num(left_num), .sec_num(sec_num), .p_num(p_num),
        .m_emergency(m_emergency), .s_emergency(s_emergency),
        .m_LRYG(m_LRYG), .s_RYG(s_RYG), .ped(ped), .phase(phase), .remain(remain)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [3:0] ph;
        logic [5:0] rem;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [7:0] lamp_ref(input logic [3:0] ph);
        case (ph)
            4'd1, 4'd7: return {4'b0001, 3'b100, 1'b0};
            4'd2:       return {4'b0010, 3'b100, 1'b0};
            4'd3:       return {4'b1100, 3'b100, 1'b0};
            4'd4, 4'd8: return {4'b0100, 3'b001, 1'b0};
            4'd5:       return {4'b0100, 3'b010, 1'b0};
            4'd6:       return {4'b0100, 3'b100, 1'b1};
            default:    return {4'b0100, 3'b100, 1'b0};
        endcase
    endfunction

    task automatic expect_st(input string nm, input logic [3:0] ph, input logic [5:0] rem);
        exp_t e;
        e.nm  = nm;
        e.ph  = ph;
        e.rem = rem;
        exp_q.push_back(e);
    endtask

    // n tick periods of 4 clocks each; returns at the negedge after the n-th tick edge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: drains expected checkpoints and checks the lamp safety rule every cycle.
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [7:0] lp;
        #2;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            lp = lamp_ref(e.ph);
            vectors++;
            if (phase !== e.ph || remain !== e.rem || {m_LRYG, s_RYG, ped} !== lp) begin
                miscompares++;
                $display("FAIL %s: got phase=%0d remain=%0d lamps=%b, expected phase=%0d remain=%0d lamps=%b",
                         e.nm, phase, remain, {m_LRYG, s_RYG, ped}, e.ph, e.rem, lp);
            end
        end
        vectors++;
        if ((m_LRYG[0] && s_RYG[0]) || (ped && (m_LRYG[0] || s_RYG[0]))) begin
            miscompares++;
            $display("FAIL safety at %0t: got m=%b s=%b ped=%b, required no conflicting green/walk",
                     $time, m_LRYG, s_RYG, ped);
        end
    end

    initial begin
        cyc(3);
        rst = 1'b0;
        expect_st("reset", 4'd0, 6'd1);
        // Idle queues: plain M_G/M_Y/AR/S_G/S_Y cycle with base durations.
        ticks(1);  expect_st("mg_entry", 4'd1, 6'd20);
        ticks(1);  expect_st("mg_count", 4'd1, 6'd19);
        ticks(18); expect_st("mg_last", 4'd1, 6'd1);
        ticks(1);  expect_st("my_entry", 4'd2, 6'd3);
        ticks(3);  expect_st("ar_after_my", 4'd0, 6'd1);
        ticks(1);  expect_st("sg_base", 4'd4, 6'd10);
        ticks(10); expect_st("sy_entry", 4'd5, 6'd3);
        ticks(3);  expect_st("ar_after_sy", 4'd0, 6'd1);
        // Long main green latched at entry, not re-evaluated.
        main_num = 3'd5;
        ticks(1);  expect_st("mg_long", 4'd1, 6'd25);
        ticks(10); expect_st("mg_long_mid", 4'd1, 6'd15);
        main_num = 3'd7;
        ticks(14); expect_st("mg_long_last", 4'd1, 6'd1);
        ticks(1);  expect_st("my_after_long", 4'd2, 6'd3);
        main_num = 3'd0;
        left_num = 3'd2;
        // Left turn and walk phases, each behind an all-red.
        ticks(3);  expect_st("ar_before_ml", 4'd0, 6'd1);
        ticks(1);  expect_st("ml_entry", 4'd3, 6'd6);
        ticks(5);  expect_st("ml_last", 4'd3, 6'd1);
        left_num = 3'd0;
        ticks(1);  expect_st("ar_after_ml", 4'd0, 6'd1);
        ticks(1);  expect_st("sg_after_ml", 4'd4, 6'd10);
        p_num = 3'd6;
        ticks(10); expect_st("sy_before_pg", 4'd5, 6'd3);
        ticks(3);  expect_st("ar_before_pg", 4'd0, 6'd1);
        ticks(1);  expect_st("pg_long", 4'd6, 6'd20);
        ticks(19); expect_st("pg_last", 4'd6, 6'd1);
        p_num = 3'd0;
        ticks(1);  expect_st("ar_after_pg", 4'd0, 6'd1);
        ticks(1);  expect_st("mg_after_pg", 4'd1, 6'd20);
        // Main emergency raised in S_G between ticks.
        ticks(20); ticks(3); ticks(1);
        expect_st("sg_pre_emg", 4'd4, 6'd10);
        ticks(3);  expect_st("sg_rem7", 4'd4, 6'd7);
        m_emergency = 1'b1;
        cyc(1);    expect_st("emg_m_sy", 4'd5, 6'd3);
        ticks(3);  expect_st("emg_m_ar", 4'd0, 6'd1);
        ticks(1);  expect_st("emg_m_entry", 4'd7, 6'd0);
        ticks(2);  expect_st("emg_m_hold", 4'd7, 6'd0);
        m_emergency = 1'b0;
        cyc(1);    expect_st("emg_m_exit", 4'd2, 6'd3);
        ticks(3);  expect_st("emg_m_resume_ar", 4'd0, 6'd1);
        ticks(1);  expect_st("emg_m_resume_sg", 4'd4, 6'd10);
        // Both emergencies in M_G: main freezes, then secondary takes over.
        ticks(10); ticks(3); ticks(1);
        expect_st("mg_pre_both", 4'd1, 6'd20);
        ticks(2);
        m_emergency = 1'b1;
        s_emergency = 1'b1;
        cyc(1);    expect_st("both_freeze", 4'd1, 6'd18);
        ticks(3);  expect_st("both_frozen", 4'd1, 6'd18);
        m_emergency = 1'b0;
        cyc(1);    expect_st("s_emg_my", 4'd2, 6'd3);
        ticks(3);  expect_st("s_emg_ar", 4'd0, 6'd1);
        ticks(1);  expect_st("emg_s_entry", 4'd8, 6'd0);
        m_emergency = 1'b1;
        cyc(1);    expect_st("emg_s_to_sy", 4'd5, 6'd3);
        ticks(3);  expect_st("emg_s_to_ar", 4'd0, 6'd1);
        ticks(1);  expect_st("emg_s_to_emg_m", 4'd7, 6'd0);
        m_emergency = 1'b0;
        s_emergency = 1'b0;
        cyc(1);    expect_st("emg_both_exit", 4'd2, 6'd3);
        ticks(3);  expect_st("emg_both_ar", 4'd0, 6'd1);
        ticks(1);  expect_st("emg_both_sg", 4'd4, 6'd10);
        // Reset in the middle of a walk phase.
        p_num = 3'd1;
        ticks(10); ticks(3);
        ticks(1);  expect_st("pg_base", 4'd6, 6'd10);
        ticks(4);  expect_st("pg_mid", 4'd6, 6'd6);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        expect_st("rst_mid_pg", 4'd0, 6'd1);
        p_num = 3'd0;
        ticks(1);  expect_st("mg_after_rst", 4'd1, 6'd20);
        // Threshold boundaries for the secondary and main qualifiers.
        ticks(20); ticks(3);
        sec_num = 3'd4;
        ticks(1);  expect_st("sg_long_th", 4'd4, 6'd15);
        main_num = 3'd3;
        ticks(15); ticks(3);
        ticks(1);  expect_st("mg_short", 4'd1, 6'd15);
        main_num = 3'd4;
        sec_num  = 3'd3;
        ticks(15); ticks(3);
        ticks(1);  expect_st("sg_short", 4'd4, 6'd5);
        // Random soak; the monitor's safety check runs on every cycle.
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            tick = ($urandom_range(3, 0) == 0);
            if ($urandom_range(15, 0) == 0) main_num = 3'($urandom_range(7, 0));
            if ($urandom_range(15, 0) == 0) left_num = 3'($urandom_range(7, 0));
            if ($urandom_range(15, 0) == 0) sec_num  = 3'($urandom_range(7, 0));
            if ($urandom_range(15, 0) == 0) p_num    = 3'($urandom_range(7, 0));
            if ($urandom_range(299, 0) == 0) m_emergency = ~m_emergency;
            if ($urandom_range(299, 0) == 0) s_emergency = ~s_emergency;
            rst = ($urandom_range(2999, 0) == 0);
        end
        tick = 1'b0;
        rst = 1'b0;
        m_emergency = 1'b0;
        s_emergency = 1'b0;
        cyc(4);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
